div_8: RTL and testbench

DIV_8 -- requirements
Module: div_8

---
 rtl/div_8.sv | 193 +++++++++++++++++++
 tb/tb_div_8.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_8.sv
// div_8: 16/8 restoring divider, one quotient bit per clock, MSB first.
// Latency: results and a one-cycle done pulse 16 edges after start is accepted
// (1 edge for divisor 0). start is ignored while busy; accepted in IDLE or DONE.
// Optional signed mode: define DIV_8_SIGNED_EN for two's-complement operands.
module div_8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;     // iteration index within RUN
  logic [15:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient bits shift in
  logic [7:0]  dvs_q, dvs_d;     // latched divisor (magnitude in signed mode)
  logic [8:0]  prem_q, prem_d;   // partial remainder
  logic        zpend_q, zpend_d; // divide-by-zero result is due at the next edge
  logic [15:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;

`ifdef DIV_8_SIGNED_EN
  logic        negq_q, negq_d;   // quotient must be negated at completion
  logic        negr_q, negr_d;   // remainder must be negated at completion
`endif

  logic        accept;
  logic [8:0]  trial;
  logic        ge;
  logic [8:0]  prem_nx;
  logic [15:0] quo_nx;
  logic [15:0] dvd_in;
  logic [7:0]  dvs_in;
  logic [15:0] quo_fin;
  logic [7:0]  rem_fin;

  // start only takes effect outside RUN, so an in-flight operation is never disturbed
  assign accept = start && (state_q != ST_RUN);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // prem_q[8] is always 0 after a step; folding it into the compare keeps the
  // step exact for any 9-bit remainder state.
  always_comb begin
    trial   = {prem_q[7:0], dvd_q[15]};
    ge      = prem_q[8] | (trial >= {1'b0, dvs_q});
    prem_nx = ge ? (trial - {1'b0, dvs_q}) : trial;
    quo_nx  = {dvd_q[14:0], ge};
  end

`ifdef DIV_8_SIGNED_EN
  // Divide magnitudes; -32768 and -128 map onto their unsigned bit patterns
  always_comb begin
    dvd_in  = dividend[15] ? (16'd0 - dividend) : dividend;
    dvs_in  = divisor[7]   ? (8'd0 - divisor)   : divisor;
    quo_fin = negq_q ? (16'd0 - quo_nx) : quo_nx;
    rem_fin = negr_q ? (8'd0 - prem_nx[7:0]) : prem_nx[7:0];
  end
`else
  // Unsigned operands pass straight through
  always_comb begin
    dvd_in  = dividend;
    dvs_in  = divisor;
    quo_fin = quo_nx;
    rem_fin = prem_nx[7:0];
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    zpend_d = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef DIV_8_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    unique case (state_q)
      ST_RUN: begin
        cnt_d  = cnt_q + 4'd1;
        dvd_d  = quo_nx;
        prem_d = prem_nx;
        if (cnt_q == 4'd15) begin
          state_d = ST_DONE;
          quo_d   = quo_fin;
          rem_d   = rem_fin;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        // IDLE or DONE: a pending divide-by-zero completes here; the raw
        // dividend low byte is reported as the remainder
        if (state_q == ST_DONE && zpend_q) begin
          quo_d  = 16'hFFFF;
          rem_d  = dvd_q[7:0];
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end

        state_d = ST_IDLE;

        if (accept) begin
          cnt_d  = 4'd0;
          prem_d = 9'd0;
          if (divisor == 8'd0) begin
            // skip iteration entirely; result lands on the next edge
            state_d = ST_DONE;
            zpend_d = 1'b1;
            dvd_d   = dividend;
            dvs_d   = 8'd0;
          end else begin
            state_d = ST_RUN;
            dvd_d   = dvd_in;
            dvs_d   = dvs_in;
`ifdef DIV_8_SIGNED_EN
            negq_d  = dividend[15] ^ divisor[7];
            negr_d  = dividend[15];
`endif
          end
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      dvd_q   <= 16'd0;
      dvs_q   <= 8'd0;
      prem_q  <= 9'd0;
      zpend_q <= 1'b0;
      quo_q   <= 16'd0;
      rem_q   <= 8'd0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      zpend_q <= zpend_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

`ifdef DIV_8_SIGNED_EN
  // Sign-correction flags, captured with the operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`endif

  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_8.sv
// Directed bench for div_8: reset, basic/extreme divisions, divide by zero,
// start-while-busy, back-to-back start in the done cycle, mid-operation reset.
// Signed vectors are exercised when DIV_8_SIGNED_EN is defined.
module tb_div_8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int compared   = 0;
  int mismatched = 0;

  div_8 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, let one edge accept them, then count edges until done (bounded)
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int cyc);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Wait for done from the current point (operands already accepted)
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int seen_done;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Basic 1000/7, busy right after acceptance
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("basic_busy", busy, 1);
    wait_done(cyc);
    chk("basic_lat", cyc, 16);
    chk("basic_quot", quotient, 142);
    chk("basic_rem", remainder, 6);
    chk("basic_dbz", div_by_zero, 0);
    chk("basic_busy_done", busy, 0);
    @(posedge clk); #1;
    chk("basic_done_pulse", done, 0);
    chk("basic_hold", quotient, 142);

    // Extremes
    run_op(16'd65535, 8'd255, cyc);
    chk("max_lat", cyc, 16);
    chk("max_quot", quotient, 257);
    chk("max_rem", remainder, 0);
    @(posedge clk); #1;
    run_op(16'd0, 8'd9, cyc);
    chk("zero_num_quot", quotient, 0);
    chk("zero_num_rem", remainder, 0);
    @(posedge clk); #1;

    // Divide by zero
    run_op(16'd5, 8'd0, cyc);
    chk("dbz_lat", cyc, 1);
    chk("dbz_quot", quotient, 16'hFFFF);
    chk("dbz_rem", remainder, 8'h05);
    chk("dbz_flag", div_by_zero, 1);
    @(posedge clk); #1;
    chk("dbz_done_pulse", done, 0);
    run_op(16'd20, 8'd3, cyc);
    chk("after_dbz_quot", quotient, 6);
    chk("after_dbz_rem", remainder, 2);
    chk("after_dbz_flag", div_by_zero, 0);
    @(posedge clk); #1;

    // Start during an active operation is ignored
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("prot_hold_prev", quotient, 6);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd300; divisor = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    chk("prot_lat", cyc, 12);
    chk("prot_quot", quotient, 142);
    chk("prot_rem", remainder, 6);

    // Back-to-back: start in the done cycle
    start = 1'b1; dividend = 16'd300; divisor = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done(cyc);
    chk("b2b_lat", cyc, 16);
    chk("b2b_quot", quotient, 75);
    chk("b2b_rem", remainder, 0);
    @(posedge clk); #1;

    // Reset in the middle of 1000/7
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_quot", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    chk("mid_rst_no_done", seen_done, 0);
    run_op(16'd50, 8'd5, cyc);
    chk("post_rst_lat", cyc, 16);
    chk("post_rst_quot", quotient, 10);
    chk("post_rst_rem", remainder, 0);
    @(posedge clk); #1;

`ifdef DIV_8_SIGNED_EN
    run_op(16'hFF9C, 8'd7, cyc);
    chk("sgn_lat", cyc, 16);
    chk("sgn_quot", quotient, 16'hFFF2);
    chk("sgn_rem", remainder, 8'hFE);
    @(posedge clk); #1;
    run_op(16'h8000, 8'hFF, cyc);
    chk("sgn_min_quot", quotient, 16'h8000);
    chk("sgn_min_rem", remainder, 0);
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
